stopwatch_ctrl: RTL and testbench

Run/pause/lap controller that sequences the 4-digit BCD counter and its four 7-seg decoder instances.
- Turns two raw push-buttons into single-cycle press events.
- Generates the counter's count enable from a programmable prescaler and clears the counter.
- Multiplexes live or frozen lap time onto the display bus.
- Sits between board buttons and the counter/decoder block. The counter's stop input is driven by ~count_en at integration.

---
 rtl/stopwatch_ctrl.sv | 147 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap controller for the BCD stopwatch counter
module stopwatch_ctrl #(
    parameter  int TICK_DIV = 4,
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic [15:0] count_in,
    output logic        count_en,
    output logic        count_clr,
    output logic [15:0] disp_data,
    output logic [1:0]  state,
    output logic        lap_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_lap_reg;
    logic          r_clr;
    logic          r_start_s1, r_start_s2, r_start_prev;
    logic          r_lap_s1, r_lap_s2, r_lap_prev;
    logic          w_start_press;
    logic          w_lap_press;
    logic          w_clr_next;
    logic          w_lap_load;
    logic          w_running;

    // Two-flop synchroniser followed by a rising-edge detector per button
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_start_s1   <= 1'b0;
            r_start_s2   <= 1'b0;
            r_start_prev <= 1'b0;
            r_lap_s1     <= 1'b0;
            r_lap_s2     <= 1'b0;
            r_lap_prev   <= 1'b0;
        end else begin
            r_start_s1   <= btn_start;
            r_start_s2   <= r_start_s1;
            r_start_prev <= r_start_s2;
            r_lap_s1     <= btn_lap;
            r_lap_s2     <= r_lap_s1;
            r_lap_prev   <= r_lap_s2;
        end
    end

    assign w_start_press = r_start_s2 & ~r_start_prev;
    assign w_lap_press   = r_lap_s2 & ~r_lap_prev;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start is checked first in every state so a simultaneous lap press is dropped
    always_comb begin
        w_state_next = r_state;
        w_clr_next   = 1'b0;
        w_lap_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_press) begin
                    w_state_next = S_RUN;
                end else if (w_lap_press) begin
                    w_clr_next = 1'b1;
                end
            end
            S_RUN: begin
                if (w_start_press) begin
                    w_state_next = S_PAUSE;
                end else if (w_lap_press) begin
                    w_state_next = S_LAP;
                    w_lap_load   = 1'b1;
                end
            end
            S_LAP: begin
                if (w_start_press) begin
                    w_state_next = S_PAUSE;
                end else if (w_lap_press) begin
                    w_state_next = S_RUN;
                end
            end
            S_PAUSE: begin
                if (w_start_press) begin
                    w_state_next = S_RUN;
                end else if (w_lap_press) begin
                    w_state_next = S_IDLE;
                    w_clr_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_running = (r_state == S_RUN) || (r_state == S_LAP);

    // Prescaler holds in PAUSE so a resumed count keeps its partial period
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (r_state == S_IDLE || w_clr_next) begin
            r_presc <= '0;
        end else if (w_running) begin
            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_lap_reg <= 16'h0000;
            r_clr     <= 1'b1;
        end else begin
            r_clr <= w_clr_next;
            if (w_lap_load) begin
                r_lap_reg <= count_in;
            end
        end
    end

    assign count_en   = w_running && (r_presc == PRESC_MAX);
    assign count_clr  = r_clr;
    assign disp_data  = (r_state == S_LAP) ? r_lap_reg : count_in;
    assign state      = r_state;
    assign lap_active = (r_state == S_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    logic        clock;
    logic        reset_n;
    logic        btn_start;
    logic        btn_lap;
    logic [15:0] count_in;
    logic        count_en;
    logic        count_clr;
    logic [15:0] disp_data;
    logic [1:0]  state;
    logic        lap_active;

    int n_tests;
    int n_fail;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .count_in   (count_in),
        .count_en   (count_en),
        .count_clr  (count_clr),
        .disp_data  (disp_data),
        .state      (state),
        .lap_active (lap_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle button pulse; returns in the first cycle after the FSM acted
    task automatic press(input logic s, input logic l);
        btn_start = s;
        btn_lap   = l;
        tick();
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        count_in  = 16'h0042;
        tick();
        tick();
        n_tests++;
        if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 00", state);
        end
        n_tests++;
        if (count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_en: got %b want 0", count_en);
        end
        n_tests++;
        if (count_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_clr: got %b want 1", count_clr);
        end
        n_tests++;
        if (disp_data !== 16'h0042 || lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_disp: got %h/%b want 0042/0", disp_data, lap_active);
        end
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (count_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_clr: got %b want 0", count_clr);
        end
    endtask

    task automatic test_start();
        logic [1:0] st_mid;
        logic       bad;
        count_in  = 16'h0000;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        tick();
        st_mid = state;
        tick();
        n_tests++;
        if (st_mid !== 2'b00 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL start_latency: got %b then %b want 00 then 01", st_mid, state);
        end
        bad = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (count_en !== ((i % 4) == 0)) begin
                bad = 1'b1;
                $display("FAIL start_en_cycle%0d: got %b want %b", i, count_en, (i % 4) == 0);
            end
            tick();
        end
        n_tests++;
        if (bad) n_fail++;
        btn_start = 1'b1;
        tick();
        tick();
        st_mid = state;
        tick();
        n_tests++;
        if (st_mid !== 2'b01 || state !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_pause: got %b then %b want 01 then 10", st_mid, state);
        end
        for (int i = 0; i < 17; i++) tick();
        btn_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (state !== 2'b10 || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_single: got state %b en %b want 10 0", state, count_en);
        end
    endtask

    task automatic test_clear();
        logic bad;
        press(1'b0, 1'b1);
        n_tests++;
        if (state !== 2'b00 || count_clr !== 1'b1 || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_pause: got state %b clr %b en %b want 00 1 0", state, count_clr, count_en);
        end
        tick();
        n_tests++;
        if (count_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_width: got %b want 0", count_clr);
        end
        press(1'b0, 1'b1);
        n_tests++;
        if (state !== 2'b00 || count_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_idle: got state %b clr %b want 00 1", state, count_clr);
        end
        tick();
        press(1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (state !== 2'b01 || count_en !== (i == 4)) begin
                bad = 1'b1;
                $display("FAIL clear_restart_cycle%0d: got state %b en %b want 01 %b", i, state, count_en, i == 4);
            end
            tick();
        end
        n_tests++;
        if (bad) n_fail++;
    endtask

    task automatic test_lap();
        logic bad;
        count_in = 16'h0123;
        press(1'b0, 1'b1);
        n_tests++;
        if (state !== 2'b11 || lap_active !== 1'b1 || disp_data !== 16'h0123 || count_en !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_enter: got state %b lap %b disp %h en %b want 11 1 0123 1", state, lap_active, disp_data, count_en);
        end
        count_in = 16'h0124;
        #1;
        n_tests++;
        if (disp_data !== 16'h0123) begin
            n_fail++;
            $display("FAIL lap_freeze_0124: got %h want 0123", disp_data);
        end
        tick();
        count_in = 16'h0125;
        #1;
        n_tests++;
        if (disp_data !== 16'h0123 || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_freeze_0125: got disp %h en %b want 0123 0", disp_data, count_en);
        end
        bad = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            if (count_en !== (j == 3)) begin
                bad = 1'b1;
                $display("FAIL lap_en_step%0d: got %b want %b", j, count_en, j == 3);
            end
        end
        n_tests++;
        if (bad) n_fail++;
        press(1'b0, 1'b1);
        count_in = 16'h0126;
        #1;
        n_tests++;
        if (state !== 2'b01 || lap_active !== 1'b0 || disp_data !== 16'h0126 || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_exit: got state %b lap %b disp %h en %b want 01 0 0126 0", state, lap_active, disp_data, count_en);
        end
        tick();
        n_tests++;
        if (count_en !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_exit_en: got %b want 1", count_en);
        end
        tick();
    endtask

    task automatic test_pause();
        logic bad;
        tick();
        tick();
        tick();
        press(1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (state !== 2'b10 || count_en !== 1'b0) bad = 1'b1;
            tick();
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL pause_hold: got state %b en %b want 10 0 for 50 cycles", state, count_en);
        end
        press(1'b1, 1'b0);
        n_tests++;
        if (state !== 2'b01 || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_entry: got state %b en %b want 01 0", state, count_en);
        end
        tick();
        n_tests++;
        if (count_en !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_first_en: got %b want 1", count_en);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        press(1'b1, 1'b0);
        count_in = 16'h0777;
        press(1'b1, 1'b1);
        n_tests++;
        if (state !== 2'b10 || lap_active !== 1'b0 || disp_data !== 16'h0777 || count_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_start_wins: got state %b lap %b disp %h clr %b want 10 0 0777 0", state, lap_active, disp_data, count_clr);
        end
        count_in = 16'h0000;
        press(1'b1, 1'b0);
        n_tests++;
        if (state !== 2'b01 || count_en !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_resume: got state %b en %b want 01 1", state, count_en);
        end
        reset_n = 1'b0;
        tick();
        n_tests++;
        if (state !== 2'b00 || count_en !== 1'b0 || count_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got state %b en %b clr %b want 00 0 1", state, count_en, count_clr);
        end
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (count_clr !== 1'b0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_release: got clr %b state %b want 0 00", count_clr, state);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        count_in  = 16'h0000;
        test_reset();
        test_start();
        test_clear();
        test_lap();
        test_pause();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
